sync_fifo_q: RTL and testbench

- Parametrised synchronous FIFO, the successor of the fixed 10-entry pipeline queue.
- Depth is any value ≥2, and pointer wrap is derived from DEPTH rather than hard-coded.
- Adds an occupancy count, programmable almost-full/almost-empty flags, a single-cycle flush, and explicit simultaneous push/pop rules.
- Exports the per-entry data and valid masks so the pipeline can search queued entries, for example store-to-load forwarding.

---
 rtl/sync_fifo_q.sv | 89 ++++++++
 tb/tb_sync_fifo_q.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_q.sv
// Parametrised synchronous FIFO with occupancy, threshold flags, single-cycle flush
// and exported per-entry valid/data for associative search of queued entries.
module sync_fifo_q #(
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned WIDTH     = 71,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 1,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [WIDTH-1:0]       pop_data,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [PTR_W-1:0]       wr_ptr,
  output logic [PTR_W-1:0]       rd_ptr,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [DEPTH*WIDTH-1:0] entry_data_pack
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_fire;
  logic             pop_fire;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Status comes from registered count only, so no path from pop_ready to push_ready.
  always_comb begin
    full         = (32'(count) == DEPTH);
    empty        = (count == '0);
    almost_full  = (32'(count) >= AFULL_TH);
    almost_empty = (32'(count) <= AEMPTY_TH);
    push_ready   = ~full;
    pop_valid    = ~empty;
    push_fire    = push_valid & ~full & ~flush;
    pop_fire     = pop_ready & ~empty & ~flush;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push_fire) wr_ptr <= next_ptr(wr_ptr);
      if (pop_fire)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // wr_ptr == rd_ptr only when full or empty, where at most one side can fire.
      if (push_fire) entry_valid[wr_ptr] <= 1'b1;
      if (pop_fire)  entry_valid[rd_ptr] <= 1'b0;
    end
  end

  // Storage is deliberately not reset; live slots are tracked by entry_valid.
  always_ff @(posedge clk) begin
    if (push_fire && !reset) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    pop_data = empty ? '0 : mem[rd_ptr];
  end

  always_comb begin
    entry_data_pack = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_data_pack[i*WIDTH +: WIDTH] = mem[i];
    end
  end

endmodule

// File: tb/tb_sync_fifo_q.sv
// Directed bench for sync_fifo_q at DEPTH=5, WIDTH=8 with a queue scoreboard
// checked after every clock edge.
module tb_sync_fifo_q;

  logic        clk = 1'b0;
  logic        reset, flush, push_valid, pop_ready;
  logic [7:0]  push_data;
  logic        push_ready, pop_valid, full, empty, almost_full, almost_empty;
  logic [7:0]  pop_data;
  logic [2:0]  count, wr_ptr, rd_ptr;
  logic [4:0]  entry_valid;
  logic [39:0] entry_data_pack;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q[$];
  int m_wr = 0, m_rd = 0;

  sync_fifo_q #(.DEPTH(5), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .entry_valid(entry_valid), .entry_data_pack(entry_data_pack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic check_model();
    logic [4:0] mask;
    int n;
    n = q.size();
    mask = '0;
    for (int k = 0; k < n; k++) mask[(m_rd + k) % 5] = 1'b1;
    check("m_count",   64'(count), 64'(n));
    check("m_wr_ptr",  64'(wr_ptr), 64'(m_wr));
    check("m_rd_ptr",  64'(rd_ptr), 64'(m_rd));
    check("m_valid",   64'(entry_valid), 64'(mask));
    check("m_popdata", 64'(pop_data), (n > 0) ? 64'(q[0]) : 64'h0);
    check("m_full",    64'(full), 64'(n == 5));
    check("m_empty",   64'(empty), 64'(n == 0));
    check("m_afull",   64'(almost_full), 64'(n >= 3));
    check("m_aempty",  64'(almost_empty), 64'(n <= 1));
    check("m_popcnt",  64'($countones(entry_valid)), 64'(count));
  endtask

  // Advance one clock, update the scoreboard from the inputs seen at the edge, compare.
  task automatic tick();
    bit pf, qf;
    pf = push_valid && (q.size() < 5) && !flush && !reset;
    qf = pop_ready && (q.size() > 0) && !flush && !reset;
    @(posedge clk);
    #1;
    if (reset || flush) begin
      q.delete();
      m_wr = 0;
      m_rd = 0;
    end else begin
      if (qf) begin void'(q.pop_front()); m_rd = (m_rd + 1) % 5; end
      if (pf) begin q.push_back(push_data); m_wr = (m_wr + 1) % 5; end
    end
    check_model();
  endtask

  task automatic set_in(input bit pv, input logic [7:0] pd, input bit pr);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    set_in(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_popdata", 64'(pop_data), 64'h0);
    check("rst_wr", 64'(wr_ptr), 64'd0);
    check("rst_rd", 64'(rd_ptr), 64'd0);
    check("rst_pready", 64'(push_ready), 64'd1);
    check("rst_aempty", 64'(almost_empty), 64'd1);

    // fill 0x11..0x55
    for (int i = 1; i <= 5; i++) begin
      set_in(1'b1, 8'(i * 8'h11), 1'b0);
      tick();
      check("fill_count", 64'(count), 64'(i));
      check("fill_afull", 64'(almost_full), 64'(i >= 3));
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_pready", 64'(push_ready), 64'd0);
    set_in(1'b1, 8'h66, 1'b0);
    tick();
    check("ovf_count", 64'(count), 64'd5);
    check("ovf_head", 64'(pop_data), 64'h11);

    // drain in order
    for (int i = 1; i <= 5; i++) begin
      set_in(1'b0, 8'h00, 1'b1);
      check("drain_data", 64'(pop_data), 64'(i * 8'h11));
      tick();
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_popdata", 64'(pop_data), 64'h0);

    // simultaneous push/pop at count=2
    set_in(1'b1, 8'hA1, 1'b0); tick();
    set_in(1'b1, 8'hA2, 1'b0); tick();
    set_in(1'b1, 8'hA3, 1'b1); tick();
    check("both2_count", 64'(count), 64'd2);
    check("both2_rd", 64'(rd_ptr), 64'd1);
    check("both2_head", 64'(pop_data), 64'hA2);
    check("both2_valid", 64'(entry_valid), 64'b00110);
    check("both2_slot2", 64'(entry_data_pack[23:16]), 64'hA3);

    // continuous push+pop across the wrap
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 8'(8'hB0 + i), 1'b1);
      tick();
      check("wrap_count", 64'(count), 64'd2);
      check("wrap_wr", 64'(wr_ptr), 64'((4 + i) % 5));
    end

    // full: only the pop fires
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'(8'hC5 + i), 1'b0);
      tick();
    end
    check("full_before", 64'(count), 64'd5);
    set_in(1'b1, 8'hC0, 1'b1);
    tick();
    check("full_both_count", 64'(count), 64'd4);

    // empty: only the push fires, visible next cycle
    set_in(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("empty_before", 64'(count), 64'd0);
    set_in(1'b1, 8'hD5, 1'b1);
    tick();
    check("empty_both_count", 64'(count), 64'd1);
    check("empty_both_data", 64'(pop_data), 64'hD5);

    // flush at count=3 with push and pop requested
    set_in(1'b1, 8'hE1, 1'b0); tick();
    set_in(1'b1, 8'hE2, 1'b0); tick();
    check("pre_flush", 64'(count), 64'd3);
    flush = 1'b1;
    set_in(1'b1, 8'hEE, 1'b1);
    tick();
    flush = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(entry_valid), 64'd0);
    check("flush_wr", 64'(wr_ptr), 64'd0);
    check("flush_rd", 64'(rd_ptr), 64'd0);
    set_in(1'b0, 8'h00, 1'b0);
    tick();
    check("flush_idle", 64'(count), 64'd0);

    // reset mid-stream at count=4
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'(8'hF0 + i), 1'b0);
      tick();
    end
    check("pre_reset", 64'(count), 64'd4);
    reset = 1'b1;
    set_in(1'b1, 8'hFF, 1'b1);
    tick();
    reset = 1'b0;
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_valid", 64'(entry_valid), 64'd0);
    check("mrst_wr", 64'(wr_ptr), 64'd0);
    check("mrst_rd", 64'(rd_ptr), 64'd0);
    check("mrst_popdata", 64'(pop_data), 64'h0);

    // random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
